// File: rtl/ram_arbiter_pkg.sv
// Shared RAM map and arbiter encodings, also used by the LED scan controller.
// RAM address layout: {foto[3:0], bank bit, 10-bit pixel address}.
package ram_arbiter_pkg;

    localparam int RAM_DATA_W = 48;
    localparam int RAM_ADDR_W = 15;
    localparam int FOTO_SLOTS = 12;
    // The photo slot occupies the top FOTO_W bits of the RAM address.
    localparam int FOTO_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_LOAD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_starve_counter.sv
// Counts consecutive display grants taken while a write is waiting.
// sat is high once the count has reached MAX.
module starve_counter #(
    parameter int MAX = 4
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [CNT_W-1:0] cnt_q;

    assign sat = (cnt_q >= CNT_W'(MAX));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !sat) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between the display reader and the photo loader.
// state | meaning
// IDLE  | no access issued this cycle
// DISP  | display read issued this cycle
// LOAD  | loader write issued this cycle
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_W     = RAM_DATA_W,
    parameter int ADDR_W     = RAM_ADDR_W,
    parameter int STARVE_MAX = 4,
    parameter int NUM_FOTO   = FOTO_SLOTS
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              wr_err,
    input  logic [3:0]        disp_foto,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_t        state_q, state_d;
    logic              armed_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic [FOTO_W-1:0] wr_foto;
    logic              wr_ok, wr_bad;
    logic              starve_inc, starve_clr, starve_sat;

    assign wr_foto = wr_addr[ADDR_W-1 -: FOTO_W];

    always_comb begin
        wr_ok      = 1'b0;
        wr_bad     = 1'b0;
        state_d    = ST_IDLE;
        addr_d     = ram_addr;
        wdata_d    = ram_wdata;
        if (armed_q && wr_req) begin
            if ((wr_foto != disp_foto) && ({1'b0, wr_foto} < (FOTO_W + 1)'(NUM_FOTO)))
                wr_ok = 1'b1;
            else
                wr_bad = 1'b1;
        end
        // A rejected write is dropped on the spot, so display never waits on it.
        if (wr_ok && (!disp_req || starve_sat)) begin
            state_d = ST_LOAD;
            addr_d  = wr_addr;
            wdata_d = wr_data;
        end else if (armed_q && disp_req) begin
            state_d = ST_DISP;
            addr_d  = disp_addr;
        end
        starve_inc = (state_d == ST_DISP) && wr_req;
        starve_clr = (state_d == ST_LOAD) || !wr_req || wr_bad;
    end

    // armed_q holds off the first grant until the second edge after reset release.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            wr_err      <= 1'b0;
            disp_rvalid <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
        end else begin
            armed_q     <= 1'b1;
            state_q     <= state_d;
            wr_err      <= wr_bad;
            disp_rvalid <= disp_gnt;
            ram_addr    <= addr_d;
            ram_wdata   <= wdata_d;
        end
    end

    assign disp_gnt   = (state_q == ST_DISP);
    assign wr_gnt     = (state_q == ST_LOAD);
    assign ram_we     = wr_gnt;
    assign disp_rdata = disp_rvalid ? ram_rdata : '0;

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .sat    (starve_sat)
    );

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, display reads, contention, write protect.
module tb_ram_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        disp_req;
    logic [14:0] disp_addr;
    logic        disp_gnt;
    logic        disp_rvalid;
    logic [47:0] disp_rdata;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [47:0] wr_data;
    logic        wr_gnt;
    logic        wr_err;
    logic [3:0]  disp_foto;
    logic [14:0] ram_addr;
    logic [47:0] ram_wdata;
    logic        ram_we;
    logic [47:0] ram_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_in = ~clk_in;

    // RAM read data: a tag plus the address, one cycle after the address.
    always @(posedge clk_in) ram_rdata <= {16'hBEEF, 17'h0, ram_addr};

    ram_arbiter dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_gnt    (disp_gnt),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_gnt      (wr_gnt),
        .wr_err      (wr_err),
        .disp_foto   (disp_foto),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_rdata   (ram_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_disp_gnt"}, disp_gnt, 0);
        chk({tag, "_wr_gnt"}, wr_gnt, 0);
        chk({tag, "_wr_err"}, wr_err, 0);
        chk({tag, "_rvalid"}, disp_rvalid, 0);
        chk({tag, "_ram_we"}, ram_we, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_wdata"}, ram_wdata, 0);
        chk({tag, "_rdata"}, disp_rdata, 0);
    endtask

    initial begin
        int rvalid_seen;
        logic exp_load;
        rst_n     = 1'b0;
        disp_req  = 1'b0;
        disp_addr = '0;
        wr_req    = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        disp_foto = 4'd0;

        repeat (3) tick();
        chk_all_zero("reset");

        // First edge after release must not grant, second one may.
        rst_n    = 1'b1;
        disp_req = 1'b1;
        tick();
        chk("first_edge_no_gnt", disp_gnt, 0);
        tick();
        chk("second_edge_gnt", disp_gnt, 1);
        disp_req = 1'b0;
        tick();
        tick();

        // Display read: grant + address, then data one cycle later.
        disp_req  = 1'b1;
        disp_addr = 15'h0805;
        tick();
        chk("rd_gnt", disp_gnt, 1);
        chk("rd_addr", ram_addr, 15'h0805);
        chk("rd_we", ram_we, 0);
        chk("rd_rvalid_early", disp_rvalid, 0);
        disp_req = 1'b0;
        tick();
        chk("rd_rvalid", disp_rvalid, 1);
        chk("rd_rdata", disp_rdata, 48'hBEEF_0000_0805);
        chk("rd_gnt_off", disp_gnt, 0);
        tick();
        chk("idle_rvalid", disp_rvalid, 0);
        chk("idle_we", ram_we, 0);
        chk("idle_addr_hold", ram_addr, 15'h0805);

        // Contention: 4 display grants then 1 write, repeating.
        disp_foto = 4'd0;
        disp_req  = 1'b1;
        disp_addr = 15'h0011;
        wr_req    = 1'b1;
        wr_addr   = 15'h1000;
        wr_data   = 48'h1234_5678_9ABC;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_load = ((i % 5) == 4);
            chk("cont_disp_gnt", disp_gnt, !exp_load);
            chk("cont_wr_gnt", wr_gnt, exp_load);
            chk("cont_ram_we", ram_we, exp_load);
            chk("cont_addr", ram_addr, exp_load ? 15'h1000 : 15'h0011);
        end
        chk("cont_wdata", ram_wdata, 48'h1234_5678_9ABC);
        disp_req = 1'b0;
        wr_req   = 1'b0;
        tick();
        tick();

        // Highest valid slot is writable.
        wr_req  = 1'b1;
        wr_addr = 15'h5812;
        wr_data = 48'h0000_1111_2222;
        tick();
        chk("slot11_gnt", wr_gnt, 1);
        chk("slot11_we", ram_we, 1);
        chk("slot11_err", wr_err, 0);
        chk("slot11_addr", ram_addr, 15'h5812);
        chk("slot11_wdata", ram_wdata, 48'h0000_1111_2222);
        wr_req = 1'b0;
        tick();
        chk("slot11_gnt_off", wr_gnt, 0);
        chk("slot11_addr_hold", ram_addr, 15'h5812);

        // Slot 12 is out of range.
        wr_req  = 1'b1;
        wr_addr = 15'h6000;
        tick();
        chk("slot12_err", wr_err, 1);
        chk("slot12_gnt", wr_gnt, 0);
        chk("slot12_we", ram_we, 0);
        wr_req = 1'b0;
        tick();
        chk("slot12_err_off", wr_err, 0);

        // Write to the slot on display is rejected.
        disp_foto = 4'd3;
        wr_req    = 1'b1;
        wr_addr   = 15'h1800;
        tick();
        chk("prot_err", wr_err, 1);
        chk("prot_gnt", wr_gnt, 0);
        chk("prot_we", ram_we, 0);
        wr_req = 1'b0;
        tick();
        chk("prot_err_pulse", wr_err, 0);

        // Rejected write alongside a display request: display still served.
        disp_req  = 1'b1;
        disp_addr = 15'h0123;
        wr_req    = 1'b1;
        tick();
        chk("rej_disp_gnt", disp_gnt, 1);
        chk("rej_wr_err", wr_err, 1);
        chk("rej_wr_gnt", wr_gnt, 0);
        chk("rej_addr", ram_addr, 15'h0123);
        disp_req = 1'b0;
        wr_req   = 1'b0;
        tick();
        chk("rej_rdata", disp_rdata, 48'hBEEF_0000_0123);
        chk("rej_err_off", wr_err, 0);

        // Protect check uses disp_foto of the decision cycle.
        disp_foto = 4'd5;
        wr_req    = 1'b1;
        wr_addr   = 15'h1800;
        wr_data   = 48'hCAFE_0000_0001;
        tick();
        chk("foto_chg_gnt", wr_gnt, 1);
        chk("foto_chg_err", wr_err, 0);
        chk("foto_chg_addr", ram_addr, 15'h1800);
        wr_req = 1'b0;
        tick();

        // Reset in the middle of a read stream.
        disp_req  = 1'b1;
        disp_addr = 15'h0077;
        repeat (3) tick();
        chk("pre_rst_gnt", disp_gnt, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick();
        rst_n    = 1'b1;
        disp_req = 1'b0;
        rvalid_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (disp_rvalid) rvalid_seen++;
        end
        chk("midrst_no_rvalid", rvalid_seen, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 48, meaning RAM word width (two pixels x RGB x 8 bit).
REQ-002 SHALL have parameter ADDR_W, default 15, meaning RAM address width ({foto[3:0], bank bit, 10-bit pixel address}).
REQ-003 SHALL have parameter STARVE_MAX, default 4, meaning the maximum number of consecutive display grants while a write is pending.
REQ-004 SHALL have parameter NUM_FOTO, default 12, meaning the number of valid photo slots.
REQ-005 SHALL have ports, one per line (name, direction, width, meaning):
  - clk_in  in  1  sole clock.
  - rst_n  in  1  reset, asynchronous assert, active-low.
  - disp_req  in  1  display read request.
  - disp_addr  in  ADDR_W  display read address.
  - disp_gnt  out  1  display read issued this cycle.
  - disp_rvalid  out  1  display read data valid.
  - disp_rdata  out  DATA_W  display read data.
  - wr_req  in  1  loader write request.
  - wr_addr  in  ADDR_W  loader write address.
  - wr_data  in  DATA_W  loader write data.
  - wr_gnt  out  1  write issued this cycle.
  - wr_err  out  1  write rejected.
  - disp_foto  in  4  photo slot currently shown; write-protected.
  - ram_addr  out  ADDR_W  RAM address.
  - ram_wdata  out  DATA_W  RAM write data.
  - ram_we  out  1  RAM write enable.
  - ram_rdata  in  DATA_W  RAM read data, one-cycle latency.
REQ-006 SHALL satisfy the decision: one clock; reset is asynchronous and active-low; the ports are clk_in and rst_n.

Function
REQ-007 SHALL implement FSM states IDLE, DISP and LOAD; the state register reflects the port granted in the current cycle.
REQ-008 SHALL register all grants and RAM outputs:
  - grant decision made at cycle N from the cycle-N requests.
  - ram_addr, ram_we and the grant strobe drive at cycle N+1.
REQ-009 SHALL, with only disp_req high, go to DISP and issue the read with ram_we=0.
REQ-010 SHALL, with only wr_req high and a permitted address, go to LOAD and drive ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data.
REQ-011 SHALL give display priority when both requests are high, unless the starve counter has reached STARVE_MAX; in that case LOAD is granted and the counter clears.
REQ-012 SHALL run the starve counter as follows:
  - increment on each DISP grant while wr_req is high.
  - clear on any LOAD grant or any cycle with wr_req low.
  - saturate at STARVE_MAX.
REQ-013 SHALL assert disp_rvalid one cycle after disp_gnt, with disp_rdata = ram_rdata (read-to-data latency 1 cycle, request-to-data 2 cycles).
REQ-014 SHALL reject a write whose wr_addr[ADDR_W-1:ADDR_W-4] equals disp_foto or is at least NUM_FOTO:
  - no ram_we, no wr_gnt.
  - wr_err pulses for one cycle in the cycle the grant would have occurred.
  - the rejected request is consumed.
REQ-015 SHALL let a rejected write not block display: a simultaneous disp_req is granted in that same cycle.
REQ-016 SHALL return to IDLE with ram_we=0 and both grants low when neither request is high; ram_addr holds its last value.
REQ-017 SHALL never assert disp_gnt and wr_gnt in the same cycle, and SHALL assert ram_we only together with wr_gnt.
REQ-018 SHALL compare the protect check against disp_foto as sampled in the decision cycle; a disp_foto change takes effect on the next decision.

Reset
REQ-019 SHALL, while rst_n is low, immediately force:
  - state=IDLE; starve counter=0.
  - disp_gnt=0, wr_gnt=0, wr_err=0, disp_rvalid=0, ram_we=0.
  - ram_addr=0, ram_wdata=0, disp_rdata=0.
REQ-020 SHALL abort any issued-but-unreturned read on reset mid-operation, with no disp_rvalid after release.
REQ-021 SHALL make its first grant no earlier than the second rising clk_in edge after rst_n deasserts.

Structure
REQ-022 SHALL take ADDR_W, DATA_W, NUM_FOTO, the FSM state encoding and the foto-field slice positions from a shared package used with the LED scan controller.
REQ-023 SHALL place the starvation counter in one sub-module, starve_counter, with ports inc, clr and a sat output; all other logic stays flat.

Verification
REQ-024 Reset mid-read: disp_req=1 for 3 cycles, then rst_n low for 1 cycle -> all outputs 0 immediately, no disp_rvalid afterwards.
REQ-025 Display only: disp_req=1, disp_addr=0x0805 -> disp_gnt=1 and ram_addr=0x0805 one cycle later; disp_rvalid=1 with disp_rdata=ram_rdata one cycle after that.
REQ-026 Contention: disp_req and wr_req held high, wr_addr=0x1000, disp_foto=0 -> pattern of 4 DISP grants, 1 LOAD grant, repeating; ram_we=1 only in the LOAD cycles.
REQ-027 Write protect: disp_foto=3, wr_addr=0x1800 -> wr_err pulses once, ram_we stays 0, no wr_gnt.
REQ-028 Out-of-range slot: wr_addr foto field=12 -> wr_err=1; foto field=11 with disp_foto=0 -> wr_gnt=1 and ram_we=1.
